// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per load/store over req/gnt + rvalid.
// Latency: store 2 cycles, load 3 cycles from start to DONE with zero-wait memory; each wait cycle adds 1.
// Backpressure: mem_stall freezes the upstream pipeline until DONE; gnt/rvalid stalls simply extend REQ/WAIT_R.
module mem_stage_lsu #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EX_MEM_valid,
  input  logic                 EX_MEM_mem_read,
  input  logic                 EX_MEM_mem_write,
  input  logic [2:0]           EX_MEM_funct3,
  input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0] EX_MEM_dataB,
  output logic                 mem_stall,
  output logic                 mem_fault,
  output logic [REG_WIDTH-1:0] DMEM_data_out,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [REG_WIDTH-1:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t                 state_q;
  logic                   req_q;
  logic                   we_q;
  logic [REG_WIDTH-1:0]   addr_q;
  logic [3:0]             be_q;
  logic [REG_WIDTH-1:0]   wdata_q;
  logic [REG_WIDTH-1:0]   data_out_q;
  logic [2:0]             f3_q;
  logic [1:0]             lo_q;

  // Register-index width is only carried through the pipeline, not used here.
  logic [REG_ADDR_WIDTH-1:0] unused_ridx;
  assign unused_ridx = '0;

  logic                 legal;
  logic                 aligned;
  logic                 start;
  logic                 bad;
  logic [3:0]           be_d;
  logic [REG_WIDTH-1:0] wdata_d;
  logic [REG_WIDTH-1:0] ext_d;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;

  // Decode legality/alignment of the instruction sitting in EX/MEM.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    if (EX_MEM_mem_read) begin
      legal = (EX_MEM_funct3 == 3'b000) || (EX_MEM_funct3 == 3'b001) ||
              (EX_MEM_funct3 == 3'b010) || (EX_MEM_funct3 == 3'b100) ||
              (EX_MEM_funct3 == 3'b101);
    end else if (EX_MEM_mem_write) begin
      legal = (EX_MEM_funct3 == 3'b000) || (EX_MEM_funct3 == 3'b001) ||
              (EX_MEM_funct3 == 3'b010);
    end
    case (EX_MEM_funct3[1:0])
      2'b01:   aligned = (EX_MEM_alu_out[0] == 1'b0);
      2'b10:   aligned = (EX_MEM_alu_out[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    // Exactly one of read/write; both set falls into bad.
    start = EX_MEM_valid & (EX_MEM_mem_read ^ EX_MEM_mem_write) & legal & aligned;
    bad   = EX_MEM_valid & (EX_MEM_mem_read | EX_MEM_mem_write) & ~start;
  end

  // Byte enables and lane-replicated store data for the request about to be issued.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = EX_MEM_dataB;
    case (EX_MEM_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << EX_MEM_alu_out[1:0];
        wdata_d = {4{EX_MEM_dataB[7:0]}};
      end
      2'b01: begin
        be_d    = EX_MEM_alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{EX_MEM_dataB[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = EX_MEM_dataB;
      end
    endcase
  end

  // Align and extend the returned word using the size/offset captured at issue.
  always_comb begin
    byte_sel = dmem_rdata[8*lo_q +: 8];
    half_sel = dmem_rdata[16*lo_q[1] +: 16];
    case (f3_q)
      3'b000:  ext_d = {{(REG_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  ext_d = {{(REG_WIDTH-16){half_sel[15]}}, half_sel};
      3'b100:  ext_d = {{(REG_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  ext_d = {{(REG_WIDTH-16){1'b0}}, half_sel};
      default: ext_d = dmem_rdata;
    endcase
  end

  // Access FSM; request fields are captured on issue and held until gnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            we_q    <= EX_MEM_mem_write;
            addr_q  <= {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= EX_MEM_funct3;
            lo_q    <= EX_MEM_alu_out[1:0];
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            req_q   <= 1'b0;
            state_q <= we_q ? S_DONE : S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (dmem_rvalid) begin
            data_out_q <= ext_d;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          // One stall-free cycle lets EX/MEM advance before we look again.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall rises in the issuing cycle so the instruction is held from the start.
  assign mem_stall = ~reset & (((state_q == S_IDLE) & start) |
                               (state_q == S_REQ) | (state_q == S_WAIT_R));
  assign mem_fault = ~reset & (state_q == S_IDLE) & bad;

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign DMEM_data_out = data_out_q;

endmodule
